// File: rtl/dp_ram_arb_pkg.sv
// dp_ram_arb_pkg: shared types, register-map constants and helpers for the dual-port RAM port arbiter.
package dp_ram_arb_pkg;

   typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_t;

   localparam logic [3:0] CONTROL  = 4'h0;
   localparam logic [3:0] DATA_IN  = 4'h1;
   localparam logic [3:0] DATA_OUT = 4'h2;
   localparam logic [3:0] STATUS   = 4'h3;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first active request at or above the pointer, wrapping around.
module rr_priority_select
   import dp_ram_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int PW    = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] winner,
   output logic [PW-1:0]    idx
);

   logic found;

   // Two ascending passes: indices at/above the pointer first, then the wrapped-around ones.
   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req[j] && PW'(j) >= ptr) begin
            winner[j] = 1'b1;
            idx       = PW'(j);
            found     = 1'b1;
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req[j] && PW'(j) < ptr) begin
            winner[j] = 1'b1;
            idx       = PW'(j);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// dp_ram_port_arbiter: round-robin sharing of the FPGA-side RAM port between N_REQ requesters,
// with per-requester locking for atomic sequences and registered RAM-side signals.
module dp_ram_port_arbiter
   import dp_ram_arb_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          lock,
   input  logic [N_REQ-1:0]          we,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   input  logic [N_REQ*4-1:0]        be,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         ADDR,
   output logic                      WRITE_F,
   output logic [DATA_W-1:0]         WRITE_DATA,
   output logic [3:0]                BYTE_ENABLE,
   input  logic [DATA_W-1:0]         READ_DATA,
   output logic [clog2_min1(N_REQ):0] owner_o
);

   localparam int PW = clog2_min1(N_REQ);

   arb_state_t          state;
   logic [PW-1:0]       ptr;
   logic [PW-1:0]       owner;
   logic [N_REQ-1:0]    sel;
   logic [PW-1:0]       sel_idx;
   logic [N_REQ-1:0]    lk_gnt;
   logic [PW-1:0]       acc_idx;
   logic                acc;
   logic                we_s;
   logic                lock_s;
   logic [ADDR_W-1:0]   addr_s;
   logic [DATA_W-1:0]   wdata_s;
   logic [3:0]          be_s;
   logic [RD_LAT:0]     rd_v;
   logic [PW-1:0]       rd_i [RD_LAT+1];

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
      return (i == PW'(N_REQ-1)) ? '0 : i + 1'b1;
   endfunction

   rr_priority_select #(.N_REQ(N_REQ), .PW(PW)) u_sel (
      .req    (req),
      .ptr    (ptr),
      .winner (sel),
      .idx    (sel_idx)
   );

   always_comb begin
      lk_gnt        = '0;
      lk_gnt[owner] = req[owner];
      gnt           = !rst ? '0 : (state == ARB_LOCKED) ? lk_gnt : sel;
      acc           = |gnt;
      acc_idx       = (state == ARB_LOCKED) ? owner : sel_idx;
   end

   always_comb begin
      we_s    = 1'b0;
      lock_s  = 1'b0;
      addr_s  = '0;
      wdata_s = '0;
      be_s    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (acc_idx == PW'(i)) begin
            we_s    = we[i];
            lock_s  = lock[i];
            addr_s  = addr[i*ADDR_W +: ADDR_W];
            wdata_s = wdata[i*DATA_W +: DATA_W];
            be_s    = be[i*4 +: 4];
         end
      end
   end

   always_comb begin
      rvalid                 = '0;
      rvalid[rd_i[RD_LAT]]   = rd_v[RD_LAT];
   end

   assign rdata   = READ_DATA;
   assign owner_o = {state == ARB_LOCKED, (state == ARB_LOCKED) ? owner : ptr};

   // Read tags ride a shift register aligned with the RAM latency; reset flushes them.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         ADDR        <= '0;
         WRITE_F     <= 1'b0;
         WRITE_DATA  <= '0;
         BYTE_ENABLE <= '0;
         rd_v        <= '0;
         for (int k = 0; k <= RD_LAT; k++) rd_i[k] <= '0;
         state       <= ARB_FREE;
         owner       <= '0;
         ptr         <= '0;
      end else begin
         WRITE_F     <= acc & we_s;
         BYTE_ENABLE <= acc ? be_s : 4'h0;
         if (acc) ADDR <= addr_s;
         if (acc && we_s) WRITE_DATA <= wdata_s;
         rd_v    <= {rd_v[RD_LAT-1:0], acc & ~we_s};
         rd_i[0] <= acc_idx;
         for (int k = 1; k <= RD_LAT; k++) rd_i[k] <= rd_i[k-1];
         if (state == ARB_FREE) begin
            if (acc && lock_s) begin
               state <= ARB_LOCKED;
               owner <= acc_idx;
            end else if (acc) begin
               ptr <= nxt(acc_idx);
            end
         end else if (!lock[owner]) begin
            state <= ARB_FREE;
            ptr   <= nxt(owner);
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// tb_dp_ram_port_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dp_ram_port_arbiter;
   import dp_ram_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int RL = 1;

   typedef struct {int due; int idx; logic [DW-1:0] d;} rd_t;

   logic            CLK = 1'b0;
   logic            rst;
   logic [N-1:0]    req, lock, we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N*4-1:0]  be;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata, WRITE_DATA, READ_DATA;
   logic [AW-1:0]   ADDR;
   logic            WRITE_F;
   logic [3:0]      BYTE_ENABLE;
   logic [1:0]      owner_o;

   logic [DW-1:0]   mem [16];
   logic [DW-1:0]   exp_mem [16];
   logic [AW-1:0]   ra;
   logic            rw;
   logic [DW-1:0]   rwd;
   logic [3:0]      rbe;

   int n_chk = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   dp_ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .CLK(CLK), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ADDR(ADDR), .WRITE_F(WRITE_F),
      .WRITE_DATA(WRITE_DATA), .BYTE_ENABLE(BYTE_ENABLE), .READ_DATA(READ_DATA), .owner_o(owner_o)
   );

   // Simple synchronous RAM: one cycle from registered ADDR to READ_DATA.
   always @(negedge CLK) begin
      ra = ADDR; rw = WRITE_F; rwd = WRITE_DATA; rbe = BYTE_ENABLE;
   end
   always @(posedge CLK) begin
      if (rw === 1'b1)
         for (int b = 0; b < 4; b++) if (rbe[b]) mem[ra][8*b +: 8] = rwd[8*b +: 8];
      READ_DATA <= mem[ra];
   end

   task automatic idle();
      req = '0; lock = '0; we = '0; addr = '0; wdata = '0; be = '0;
   endtask

   task automatic drive(input int i, input bit r, input bit w, input bit l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
      req[i] = r; we[i] = w; lock[i] = l;
      addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d; be[i*4 +: 4] = b;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      repeat (2) @(posedge CLK);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      req = 2'b11;
      @(posedge CLK); #1;
      n_chk++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b exp 00", gnt); else n_pass++;
      n_chk++; if (WRITE_F !== 1'b0) $display("FAIL rst_write_f got %b exp 0", WRITE_F); else n_pass++;
      n_chk++; if (ADDR !== 4'h0) $display("FAIL rst_addr got %h exp 0", ADDR); else n_pass++;
      n_chk++; if (WRITE_DATA !== 32'h0) $display("FAIL rst_wdata got %h exp 0", WRITE_DATA); else n_pass++;
      n_chk++; if (owner_o !== 2'b00) $display("FAIL rst_owner got %b exp 00", owner_o); else n_pass++;
      rst = 1'b1;
      idle();
      drive(0, 1, 1, 0, 4'h5, 32'hDEADBEEF, 4'hF);
      @(posedge CLK); #1;
      n_chk++; if (WRITE_F !== 1'b1) $display("FAIL pre_async_wf got %b exp 1", WRITE_F); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++; if (WRITE_F !== 1'b0) $display("FAIL async_wf got %b exp 0", WRITE_F); else n_pass++;
      n_chk++; if (BYTE_ENABLE !== 4'h0) $display("FAIL async_be got %h exp 0", BYTE_ENABLE); else n_pass++;
      n_chk++; if (rvalid !== 2'b00) $display("FAIL async_rvalid got %b exp 00", rvalid); else n_pass++;
      n_chk++; if (gnt !== 2'b00) $display("FAIL async_gnt got %b exp 00", gnt); else n_pass++;
      n_chk++; if (owner_o !== 2'b00) $display("FAIL async_owner got %b exp 00", owner_o); else n_pass++;
      idle();
   endtask

   task automatic test_single_read();
      do_reset();
      mem[1] = 32'h000000A5;
      drive(0, 1, 0, 0, DATA_IN, 32'h0, 4'hF);
      #1;
      n_chk++; if (gnt !== 2'b01) $display("FAIL rd_gnt got %b exp 01", gnt); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (ADDR !== 4'h1) $display("FAIL rd_addr got %h exp 1", ADDR); else n_pass++;
      n_chk++; if (WRITE_F !== 1'b0) $display("FAIL rd_wf got %b exp 0", WRITE_F); else n_pass++;
      idle();
      @(posedge CLK); #1;
      n_chk++; if (rvalid !== 2'b01) $display("FAIL rd_rvalid got %b exp 01", rvalid); else n_pass++;
      n_chk++; if (rdata !== 32'hA5) $display("FAIL rd_rdata got %h exp a5", rdata); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (rvalid !== 2'b00) $display("FAIL rd_rvalid_end got %b exp 00", rvalid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] e;
      do_reset();
      drive(0, 1, 0, 0, CONTROL, 32'h0, 4'hF);
      drive(1, 1, 0, 0, DATA_OUT, 32'h0, 4'hF);
      for (int k = 0; k < 6; k++) begin
         e = (k % 2 == 1) ? 2'b10 : 2'b01;
         #1;
         n_chk++; if (gnt !== e) $display("FAIL b2b_gnt[%0d] got %b exp %b", k, gnt, e); else n_pass++;
         if (k >= 2) begin
            n_chk++; if (rvalid !== e) $display("FAIL b2b_rvalid[%0d] got %b exp %b", k, rvalid, e); else n_pass++;
            n_chk++; if (rdata !== ((k % 2 == 1) ? mem[2] : mem[0]))
               $display("FAIL b2b_rdata[%0d] got %h", k, rdata); else n_pass++;
         end
         @(posedge CLK); #1;
      end
      idle();
   endtask

   task automatic test_lock();
      do_reset();
      drive(1, 1, 0, 0, DATA_IN, 32'h0, 4'hF);
      drive(0, 1, 0, 1, CONTROL, 32'h0, 4'hF);
      #1;
      n_chk++; if (gnt !== 2'b01) $display("FAIL lk_gnt0 got %b exp 01", gnt); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (owner_o !== 2'b10) $display("FAIL lk_owner1 got %b exp 10", owner_o); else n_pass++;
      drive(0, 0, 0, 1, CONTROL, 32'h0, 4'h0);
      #1;
      n_chk++; if (gnt !== 2'b00) $display("FAIL lk_gnt1 got %b exp 00", gnt); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (owner_o !== 2'b10) $display("FAIL lk_owner2 got %b exp 10", owner_o); else n_pass++;
      n_chk++; if (rvalid !== 2'b01) $display("FAIL lk_rvalid got %b exp 01", rvalid); else n_pass++;
      drive(0, 1, 1, 0, STATUS, 32'h1, 4'hF);
      #1;
      n_chk++; if (gnt !== 2'b01) $display("FAIL lk_gnt2 got %b exp 01", gnt); else n_pass++;
      @(posedge CLK); #1;
      drive(0, 0, 0, 0, 4'h0, 32'h0, 4'h0);
      n_chk++; if (WRITE_F !== 1'b1 || ADDR !== STATUS || WRITE_DATA !== 32'h1)
         $display("FAIL lk_write got wf=%b addr=%h wd=%h exp 1/3/1", WRITE_F, ADDR, WRITE_DATA); else n_pass++;
      n_chk++; if (owner_o !== 2'b01) $display("FAIL lk_owner3 got %b exp 01", owner_o); else n_pass++;
      #1;
      n_chk++; if (gnt !== 2'b10) $display("FAIL lk_gnt3 got %b exp 10", gnt); else n_pass++;
      @(posedge CLK); #1;
      idle();
   endtask

   task automatic test_write();
      do_reset();
      drive(1, 1, 1, 0, DATA_OUT, 32'h15, 4'hF);
      #1;
      n_chk++; if (gnt !== 2'b10) $display("FAIL wr_gnt got %b exp 10", gnt); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (WRITE_F !== 1'b1) $display("FAIL wr_wf got %b exp 1", WRITE_F); else n_pass++;
      n_chk++; if (ADDR !== 4'h2) $display("FAIL wr_addr got %h exp 2", ADDR); else n_pass++;
      n_chk++; if (WRITE_DATA !== 32'h15) $display("FAIL wr_wd got %h exp 15", WRITE_DATA); else n_pass++;
      n_chk++; if (BYTE_ENABLE !== 4'hF) $display("FAIL wr_be got %h exp f", BYTE_ENABLE); else n_pass++;
      idle();
      @(posedge CLK); #1;
      n_chk++; if (WRITE_F !== 1'b0 || BYTE_ENABLE !== 4'h0)
         $display("FAIL wr_idle got wf=%b be=%h exp 0/0", WRITE_F, BYTE_ENABLE); else n_pass++;
      n_chk++; if (ADDR !== 4'h2 || WRITE_DATA !== 32'h15)
         $display("FAIL wr_hold got addr=%h wd=%h exp 2/15", ADDR, WRITE_DATA); else n_pass++;
      n_chk++; if (rvalid !== 2'b00) $display("FAIL wr_rvalid1 got %b exp 00", rvalid); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (rvalid !== 2'b00) $display("FAIL wr_rvalid2 got %b exp 00", rvalid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(0, 1, 0, 0, DATA_IN, 32'h0, 4'hF);
      @(posedge CLK); #1;
      idle();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_chk++; if (rvalid !== 2'b00) $display("FAIL rm_rvalid1 got %b exp 00", rvalid); else n_pass++;
      for (int k = 2; k <= 4; k++) begin
         @(posedge CLK); #1;
         n_chk++; if (rvalid !== 2'b00) $display("FAIL rm_rvalid%0d got %b exp 00", k, rvalid); else n_pass++;
      end
      drive(0, 1, 0, 0, CONTROL, 32'h0, 4'hF);
      drive(1, 1, 0, 0, DATA_IN, 32'h0, 4'hF);
      #1;
      n_chk++; if (gnt !== 2'b01) $display("FAIL rm_gnt got %b exp 01", gnt); else n_pass++;
      n_chk++; if (owner_o !== 2'b00) $display("FAIL rm_owner got %b exp 00", owner_o); else n_pass++;
      @(posedge CLK); #1;
      idle();
   endtask

   task automatic test_random();
      logic [N-1:0]  g, e_rv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd;
      logic          e_wf;
      logic [3:0]    e_be;
      logic [1:0]    e_own;
      bit            m_locked;
      int            m_owner, m_ptr, cyc, w;
      bit            pend [N];
      bit            p_we [N];
      bit            p_lk [N];
      logic [AW-1:0] p_a [N];
      logic [DW-1:0] p_wd [N];
      logic [3:0]    p_be [N];
      rd_t           rq [$];
      rd_t           ent;
      do_reset();
      for (int k = 0; k < 16; k++) exp_mem[k] = mem[k];
      m_locked = 0; m_owner = 0; m_ptr = 0; cyc = 0;
      e_addr = '0; e_wd = '0; e_wf = 1'b0; e_be = '0;
      for (int i = 0; i < N; i++) pend[i] = 0;
      for (int c = 0; c < 600; c++) begin
         e_own = m_locked ? {1'b1, 1'(m_owner)} : {1'b0, 1'(m_ptr)};
         e_rv = '0; e_rd = '0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            ent = rq.pop_front();
            e_rv[ent.idx] = 1'b1;
            e_rd = ent.d;
         end
         n_chk++; if (WRITE_F !== e_wf) $display("FAIL rnd_wf c=%0d got %b exp %b", c, WRITE_F, e_wf); else n_pass++;
         n_chk++; if (ADDR !== e_addr) $display("FAIL rnd_addr c=%0d got %h exp %h", c, ADDR, e_addr); else n_pass++;
         n_chk++; if (WRITE_DATA !== e_wd) $display("FAIL rnd_wd c=%0d got %h exp %h", c, WRITE_DATA, e_wd); else n_pass++;
         n_chk++; if (BYTE_ENABLE !== e_be) $display("FAIL rnd_be c=%0d got %h exp %h", c, BYTE_ENABLE, e_be); else n_pass++;
         n_chk++; if (owner_o !== e_own) $display("FAIL rnd_owner c=%0d got %b exp %b", c, owner_o, e_own); else n_pass++;
         n_chk++; if (rvalid !== e_rv) $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, rvalid, e_rv); else n_pass++;
         if (e_rv != '0) begin
            n_chk++; if (rdata !== e_rd) $display("FAIL rnd_rdata c=%0d got %h exp %h", c, rdata, e_rd); else n_pass++;
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(2) != 0) begin
               pend[i] = 1; p_we[i] = 1'($urandom_range(1)); p_lk[i] = ($urandom_range(3) == 0);
               p_a[i] = 4'($urandom_range(15)); p_wd[i] = $urandom; p_be[i] = 4'($urandom_range(15));
            end
            if (pend[i]) drive(i, 1, p_we[i], p_lk[i], p_a[i], p_wd[i], p_be[i]);
            else drive(i, 0, 0, (m_locked && m_owner == i) ? ($urandom_range(2) != 0) : 1'b0, '0, '0, '0);
         end
         #1;
         // Expected grant straight from the arbitration rules.
         g = '0; w = -1;
         if (m_locked) begin
            if (req[m_owner]) w = m_owner;
         end else begin
            for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
         if (w >= 0) g[w] = 1'b1;
         n_chk++; if (gnt !== g) $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, g); else n_pass++;
         if (w >= 0) begin
            pend[w] = 0;
            e_wf = p_we[w]; e_be = p_be[w]; e_addr = p_a[w];
            if (p_we[w]) begin
               e_wd = p_wd[w];
               for (int b = 0; b < 4; b++) if (p_be[w][b]) exp_mem[p_a[w]][8*b +: 8] = p_wd[w][8*b +: 8];
            end else begin
               rq.push_back('{due: cyc + 1 + RL, idx: w, d: exp_mem[p_a[w]]});
            end
         end else begin
            e_wf = 1'b0; e_be = '0;
         end
         if (!m_locked) begin
            if (w >= 0 && lock[w]) begin m_locked = 1; m_owner = w; end
            else if (w >= 0) m_ptr = (w + 1) % N;
         end else if (!lock[m_owner]) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
         end
         @(posedge CLK); cyc++; #1;
      end
      idle();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_lock();
      test_write();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
